ram_arbiter: RTL and testbench

- Shares one single-port, byte-write-enabled, word-addressed RAM between two requesters: m0 (CPU data port) and m1 (DMA/video fetch).
- Sits directly in front of the RAM instance. It drives the RAM address, write data and byte enables, and routes the 1-cycle-latency read data back to the requester that issued the read.
- Arbitration is round-robin with a bounded burst, so neither requester can starve the other.

---
 rtl/ram_arbiter_if.sv | 20 ++
 rtl/ram_arbiter.sv | 126 ++++++++++++
 tb/tb_ram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Request/response bundle for one requester of the shared RAM arbiter.
// The requester uses the master modport and the arbiter uses the slave modport.
`ifndef RAM_ADDR_WIDTH
`define RAM_ADDR_WIDTH 10
`endif

interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = `RAM_ADDR_WIDTH
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            we;
  logic [31:0]           wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [31:0]           rdata;

  modport master (output req, addr, we, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter with bounded bursts, sharing one single-port byte-write RAM
// between a CPU data port (m0) and a DMA/video fetch port (m1).
`ifndef RAM_ADDR_WIDTH
`define RAM_ADDR_WIDTH 10
`endif

module ram_arbiter #(
  parameter int ADDR_WIDTH = `RAM_ADDR_WIDTH,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_arbiter_if.slave          m0,
  ram_arbiter_if.slave          m1,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  output logic [3:0]            ram_we,
  input  logic [31:0]           ram_dout
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_M0   = 2'd1;
  localparam logic [1:0] OWN_M1   = 2'd2;
  localparam logic       RR_M0    = 1'b0;
  localparam logic       RR_M1    = 1'b1;
  localparam logic [3:0] MAX_CNT  = 4'(MAX_BURST);

  logic [1:0] owner;
  logic       rr_last;
  logic [3:0] burst_cnt;
  logic       rd_pend0;
  logic       rd_pend1;

  logic       gnt0;
  logic       gnt1;
  logic       burst_left;
  logic [1:0] gnt_owner;

  // Grants are forced low while reset is held, so nothing reaches the RAM.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    burst_left = (burst_cnt < MAX_CNT);
    if (rst_n) begin
      case ({m0.req, m1.req})
        2'b10: gnt0 = 1'b1;
        2'b01: gnt1 = 1'b1;
        2'b11: begin
          case (owner)
            OWN_M0: begin
              gnt0 = burst_left;
              gnt1 = !burst_left;
            end
            OWN_M1: begin
              gnt1 = burst_left;
              gnt0 = !burst_left;
            end
            default: begin
              gnt0 = (rr_last == RR_M1);
              gnt1 = (rr_last == RR_M0);
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt_owner = OWN_NONE;
    if (gnt0)      gnt_owner = OWN_M0;
    else if (gnt1) gnt_owner = OWN_M1;
  end

  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = '0;
    if (gnt0) begin
      ram_addr = m0.addr;
      ram_din  = m0.wdata;
      ram_we   = m0.we;
    end else if (gnt1) begin
      ram_addr = m1.addr;
      ram_din  = m1.wdata;
      ram_we   = m1.we;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_NONE;
      rr_last   <= RR_M1;
      burst_cnt <= 4'd0;
      rd_pend0  <= 1'b0;
      rd_pend1  <= 1'b0;
    end else begin
      rd_pend0 <= gnt0 && (m0.we == 4'b0000);
      rd_pend1 <= gnt1 && (m1.we == 4'b0000);
      if (gnt_owner == OWN_NONE) begin
        owner     <= OWN_NONE;
        burst_cnt <= 4'd0;
      end else if (gnt_owner == owner) begin
        // Saturate so a lone streaming requester keeps the grant indefinitely.
        if (burst_cnt < MAX_CNT) burst_cnt <= burst_cnt + 4'd1;
      end else begin
        owner     <= gnt_owner;
        burst_cnt <= 4'd1;
        rr_last   <= gnt1 ? RR_M1 : RR_M0;
      end
    end
  end

  // Read data is broadcast; rvalid tells each requester whether it is theirs.
  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = rd_pend0;
  assign m1.rvalid = rd_pend1;
  assign m0.rdata  = ram_dout;
  assign m1.rdata  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: RAM model, history-based grant reference,
// directed scenarios and randomized two-requester traffic.
module tb_ram_arbiter;

  localparam int AW = 10;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic [3:0]    ram_we;
  logic [31:0]   ram_dout = '0;

  ram_arbiter_if #(.ADDR_WIDTH(AW)) m0_if ();
  ram_arbiter_if #(.ADDR_WIDTH(AW)) m1_if ();

  ram_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0       (m0_if),
    .m1       (m1_if),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read data and per-byte write enables.
  logic [31:0] ram_mem [1 << AW] = '{default: 32'h0};
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    ram_dout <= ram_mem[ram_addr];
  end

  // Reference state: expected memory, grant history (0, 1, 2 = none), pending reads.
  logic [31:0] exp_mem [1 << AW] = '{default: 32'h0};
  int          hist[$];
  logic        exp_rv0 = 1'b0, exp_rv1 = 1'b0;
  logic [31:0] exp_rd0 = '0, exp_rd1 = '0;

  // Pending transaction per requester, held until granted.
  logic          t0_v = 1'b0, t1_v = 1'b0;
  logic [AW-1:0] t0_a = '0, t1_a = '0;
  logic [3:0]    t0_we = '0, t1_we = '0;
  logic [31:0]   t0_d = '0, t1_d = '0;

  // Observations from the most recent cycle.
  logic        g0_seen, g1_seen, rv0_seen, rv1_seen;
  logic [31:0] rd0_seen, rd1_seen;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Grant rule from history: run length of the previous owner and last real winner.
  function automatic int predict(input logic r0, input logic r1);
    int prev, run, lastg;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (!r0 && !r1) return 2;
    prev = (hist.size() > 0) ? hist[hist.size()-1] : 2;
    if (prev == 2) begin
      lastg = 1;
      for (int i = hist.size() - 1; i >= 0; i--)
        if (hist[i] != 2) begin
          lastg = hist[i];
          break;
        end
      return 1 - lastg;
    end
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != prev) break;
      run++;
    end
    return (run < MB) ? prev : 1 - prev;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (we[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // One clock cycle: drive pending transactions, check at negedge, update model.
  task automatic cycle();
    int w;
    m0_if.req = t0_v; m0_if.addr = t0_a; m0_if.we = t0_we; m0_if.wdata = t0_d;
    m1_if.req = t1_v; m1_if.addr = t1_a; m1_if.we = t1_we; m1_if.wdata = t1_d;
    @(negedge clk);
    w = predict(t0_v, t1_v);
    check("m0_gnt", {31'b0, m0_if.gnt}, {31'b0, w == 0});
    check("m1_gnt", {31'b0, m1_if.gnt}, {31'b0, w == 1});
    check("m0_rvalid", {31'b0, m0_if.rvalid}, {31'b0, exp_rv0});
    check("m1_rvalid", {31'b0, m1_if.rvalid}, {31'b0, exp_rv1});
    if (exp_rv0) check("m0_rdata", m0_if.rdata, exp_rd0);
    if (exp_rv1) check("m1_rdata", m1_if.rdata, exp_rd1);
    if (w == 0) begin
      check("ram_addr_m0", 32'(ram_addr), 32'(t0_a));
      check("ram_we_m0", 32'(ram_we), 32'(t0_we));
      if (t0_we != 4'b0) check("ram_din_m0", ram_din, t0_d);
    end else if (w == 1) begin
      check("ram_addr_m1", 32'(ram_addr), 32'(t1_a));
      check("ram_we_m1", 32'(ram_we), 32'(t1_we));
      if (t1_we != 4'b0) check("ram_din_m1", ram_din, t1_d);
    end else begin
      check("ram_idle", {ram_din[31:4], ram_we} | 32'(ram_addr), 32'h0);
    end
    g0_seen = m0_if.gnt;  g1_seen = m1_if.gnt;
    rv0_seen = m0_if.rvalid; rv1_seen = m1_if.rvalid;
    rd0_seen = m0_if.rdata;  rd1_seen = m1_if.rdata;

    hist.push_back(w);
    exp_rv0 = (w == 0) && (t0_we == 4'b0);
    exp_rv1 = (w == 1) && (t1_we == 4'b0);
    if (w == 0) begin
      exp_rd0 = exp_mem[t0_a];
      exp_mem[t0_a] = merge(exp_mem[t0_a], t0_d, t0_we);
      t0_v = 1'b0;
    end else if (w == 1) begin
      exp_rd1 = exp_mem[t1_a];
      exp_mem[t1_a] = merge(exp_mem[t1_a], t1_d, t1_we);
      t1_v = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic arm0(input logic [AW-1:0] a, input logic [3:0] we, input logic [31:0] d);
    t0_v = 1'b1; t0_a = a; t0_we = we; t0_d = d;
  endtask

  task automatic arm1(input logic [AW-1:0] a, input logic [3:0] we, input logic [31:0] d);
    t1_v = 1'b1; t1_a = a; t1_we = we; t1_d = d;
  endtask

  // Reset with both requests asserted: everything must stay quiet while rst_n is low.
  task automatic do_reset();
    rst_n = 1'b0;
    hist.delete();
    exp_rv0 = 1'b0; exp_rv1 = 1'b0; t0_v = 1'b0; t1_v = 1'b0;
    m0_if.req = 1'b1; m0_if.addr = AW'(3); m0_if.we = 4'hF; m0_if.wdata = 32'h5555_5555;
    m1_if.req = 1'b1; m1_if.addr = AW'(4); m1_if.we = 4'hF; m1_if.wdata = 32'hAAAA_AAAA;
    @(negedge clk);
    check("rst_m0_gnt", {31'b0, m0_if.gnt}, 32'h0);
    check("rst_m1_gnt", {31'b0, m1_if.gnt}, 32'h0);
    check("rst_m0_rvalid", {31'b0, m0_if.rvalid}, 32'h0);
    check("rst_m1_rvalid", {31'b0, m1_if.rvalid}, 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_ram_din", ram_din, 32'h0);
    m0_if.req = 1'b0; m1_if.req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    m0_if.req = 1'b0; m0_if.addr = '0; m0_if.we = '0; m0_if.wdata = '0;
    m1_if.req = 1'b0; m1_if.addr = '0; m1_if.we = '0; m1_if.wdata = '0;
    do_reset();

    // Write then read back through m0.
    arm0(AW'(5), 4'hF, 32'hDEADBEEF); cycle();
    check("wr5_gnt", {31'b0, g0_seen}, 32'h1);
    arm0(AW'(5), 4'h0, 32'h0); cycle();
    check("rd5_gnt", {31'b0, g0_seen}, 32'h1);
    cycle();
    check("rd5_rvalid", {31'b0, rv0_seen}, 32'h1);
    check("rd5_data", rd0_seen, 32'hDEADBEEF);
    check("rd5_m1_rvalid", {31'b0, rv1_seen}, 32'h0);

    // Partial byte write keeps the untouched bytes.
    arm0(AW'(7), 4'hF, 32'h11223344); cycle();
    arm0(AW'(7), 4'b0100, 32'hAABBCCDD); cycle();
    arm0(AW'(7), 4'h0, 32'h0); cycle();
    cycle();
    check("byte_en_data", rd0_seen, 32'h11BB3344);

    // Contention from idle: 4/4 alternation starting with m0.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (!t0_v) arm0(AW'($urandom_range(0, 15)), 4'h0, 32'h0);
      if (!t1_v) arm1(AW'($urandom_range(0, 15)), 4'h0, 32'h0);
      cycle();
      check("rr_pattern_m1", {31'b0, g1_seen}, 32'((i / 4) % 2));
    end
    for (int i = 0; i < 4 && (t0_v || t1_v); i++) cycle();
    cycle();

    // Preload 0..9 via m0, then m1 streams reads back-to-back.
    for (int i = 0; i < 10; i++) begin
      arm0(AW'(i), 4'hF, 32'hC0DE_0000 + 32'(i * 17)); cycle();
    end
    cycle();
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) arm1(AW'(i), 4'h0, 32'h0);
      cycle();
      if (i < 10) check("stream_gnt", {31'b0, g1_seen}, 32'h1);
      if (i > 0) begin
        check("stream_rvalid", {31'b0, rv1_seen}, 32'h1);
        check("stream_data", rd1_seen, 32'hC0DE_0000 + 32'((i - 1) * 17));
      end
    end

    // Interleaved reads route data to the right requester.
    arm0(AW'(1), 4'hF, 32'hA); cycle();
    arm0(AW'(2), 4'hF, 32'hB); cycle();
    cycle();
    arm0(AW'(1), 4'h0, 32'h0); cycle();
    check("il_g0", {31'b0, g0_seen}, 32'h1);
    arm1(AW'(2), 4'h0, 32'h0); cycle();
    check("il_g1", {31'b0, g1_seen}, 32'h1);
    check("il_rv0", {31'b0, rv0_seen}, 32'h1);
    check("il_rd0", rd0_seen, 32'hA);
    check("il_rv1_early", {31'b0, rv1_seen}, 32'h0);
    cycle();
    check("il_rv1", {31'b0, rv1_seen}, 32'h1);
    check("il_rd1", rd1_seen, 32'hB);
    check("il_rv0_late", {31'b0, rv0_seen}, 32'h0);

    // Asynchronous reset between a read grant and its edge drops the rvalid.
    m0_if.req = 1'b1; m0_if.addr = AW'(1); m0_if.we = 4'h0;
    m1_if.req = 1'b0;
    @(negedge clk);
    check("mid_rst_gnt", {31'b0, m0_if.gnt}, 32'h1);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_gnt_low", {31'b0, m0_if.gnt}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("mid_rst_rvalid", {31'b0, m0_if.rvalid}, 32'h0);
    end
    m0_if.req = 1'b0;
    hist.delete(); exp_rv0 = 1'b0; exp_rv1 = 1'b0; t0_v = 1'b0; t1_v = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    arm0(AW'(3), 4'h0, 32'h0); arm1(AW'(4), 4'h0, 32'h0); cycle();
    check("post_rst_first_m0", {31'b0, g0_seen}, 32'h1);
    for (int i = 0; i < 4 && (t0_v || t1_v); i++) cycle();

    // Randomized traffic with frequent contention and read-after-write hits.
    for (int i = 0; i < 3000; i++) begin
      if (!t0_v && ($urandom_range(0, 3) != 0))
        arm0(AW'($urandom_range(0, 15)),
             ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom);
      if (!t1_v && ($urandom_range(0, 3) != 0))
        arm1(AW'($urandom_range(0, 15)),
             ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom);
      cycle();
    end
    for (int i = 0; i < 6 && (t0_v || t1_v); i++) cycle();
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
